mdu: RTL and testbench

Iterative multiply/divide unit for the MIPS datapath, sitting directly downstream of the ALU operand-B select. It consumes operand A (`rs` read data) and the selected operand B, and executes MULT, MULTU, DIV and DIVU over 33 cycles. Results go into architectural HI/LO registers that MFHI/MFLO read combinationally. The core stalls on `busy`, and MTHI/MTLO write HI/LO directly.

---
 rtl/mdu_pkg.sv | 23 ++
 rtl/mdu.sv | 163 ++++++++++++++++
 tb/tb_mdu.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mdu_pkg;

  localparam int unsigned WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

  function automatic logic is_div_op(input op_e o);
    return (o == OP_DIVU) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/mdu.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One radix-2 step per cycle on unsigned magnitudes; signs are restored at FIX.
module mdu #(
  parameter int unsigned WIDTH = mdu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  import mdu_pkg::*;

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned ACC_W = 2 * WIDTH;

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_a_q, neg_a_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;
  logic               busy_q, busy_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic               div_fit;
  logic [WIDTH-1:0]   div_diff;
  logic [ACC_W-1:0]   prod;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Magnitudes of the launching operands (op[0] selects signed)
  assign a_neg = op[0] & operand_a[WIDTH-1];
  assign b_neg = op[0] & operand_b[WIDTH-1];
  assign mag_a = a_neg ? -operand_a : operand_a;
  assign mag_b = b_neg ? -operand_b : operand_b;

  // Multiply: acc = {partial product, remaining multiplier bits}
  assign mul_sum = {1'b0, acc_q[ACC_W-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

  // Divide: acc = {partial remainder, dividend bits / quotient bits}
  assign div_trial = acc_q[ACC_W-1:WIDTH-1];
  assign div_fit   = div_trial >= {1'b0, opnd_q};
  assign div_diff  = div_trial[WIDTH-1:0] - opnd_q;

  assign prod    = neg_res_q ? -acc_q : acc_q;
  assign quo_fix = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix = neg_a_q ? -acc_q[ACC_W-1:WIDTH] : acc_q[ACC_W-1:WIDTH];

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    neg_res_d  = neg_res_q;
    neg_a_d    = neg_a_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;

    case (state_q)
      ST_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          op_d       = op_e'(op);
          neg_res_d  = a_neg ^ b_neg;
          neg_a_d    = a_neg;
          div_zero_d = 1'b0;
          cnt_d      = '0;
          if (op[1]) begin
            opnd_d = mag_b;
            acc_d  = {{WIDTH{1'b0}}, mag_a};
          end else begin
            opnd_d = mag_a;
            acc_d  = {{WIDTH{1'b0}}, mag_b};
          end
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        if (is_div_op(op_q)) begin
          acc_d = {(div_fit ? div_diff : div_trial[WIDTH-1:0]), acc_q[WIDTH-2:0], div_fit};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
        if (is_div_op(op_q)) begin
          // Zero divisor: quotient is all ones, remainder restores the dividend
          div_zero_d = (opnd_q == '0);
          lo_d       = (opnd_q == '0) ? '1 : quo_fix;
          hi_d       = rem_fix;
        end else begin
          hi_d = prod[ACC_W-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_MULTU;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      neg_res_q  <= 1'b0;
      neg_a_q    <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      neg_res_q  <= neg_res_d;
      neg_a_q    <= neg_a_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      busy_q     <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: stimulus queues expected HI/LO/div_zero/latency,
// a negedge monitor checks them whenever done pulses.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  mdu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int unsigned due;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'(0));
      end else begin
        e = sb.pop_front();
        chk({e.name, "_hi"},   hi, e.hi);
        chk({e.name, "_lo"},   lo, e.lo);
        chk({e.name, "_dz"},   32'(div_zero), 32'(e.dz));
        chk({e.name, "_lat"},  32'(cyc), 32'(e.due));
        chk({e.name, "_busy"}, 32'(busy), 32'(0));
      end
    end
  end

  // Drive start for one cycle from the current time; optionally expect a result
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                       input string nm, input bit push);
    exp_t e;
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    if (push) begin
      e.hi = ehi; e.lo = elo; e.dz = edz; e.due = cyc + 34; e.name = nm;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 60);
    if (!done) chk("done_timeout", 32'(done), 32'(1));
  endtask

  task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                     input string nm);
    issue(o, a, b, ehi, elo, edz, nm, 1'b1);
    wait_done();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_dz",   32'(div_zero), 32'(0));
    chk("rst_hi",   hi, 32'h0);
    chk("rst_lo",   lo, 32'h0);

    // Arithmetic vectors, issued back-to-back in each done cycle
    run(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu_max");
    run(OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, "mult_m3x7");
    run(OP_MULT,  32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_0019, 1'b0, "mult_m5xm5");
    run(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_m7d2");
    run(OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0, "divu_100d7");
    run(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, "div_minovf");
    run(OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, "div_7dm2");
    run(OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, "mult_minsq");
    run(OP_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0, "multu_shift");
    run(OP_DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1, "divu_by0");

    // MTLO in idle after a gap
    @(posedge clk);
    #1 lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 lo_we = 1'b0;
    @(negedge clk);
    chk("mtlo_lo", lo, 32'hDEAD_BEEF);
    chk("mtlo_hi", hi, 32'd100);
    chk("idle_dz_held", 32'(div_zero), 32'(1));

    run(OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, "multu_2x3");
    run(OP_DIVU,  32'd9, 32'd3, 32'd0, 32'd3, 1'b0, "divu_9d3_b2b");

    // MTHI in the same cycle as start: write lands, then FIX overwrites
    @(posedge clk);
    #1 hi_we = 1'b1; wdata = 32'hCAFE_F00D;
    issue(OP_DIVU, 32'd17, 32'd5, 32'd2, 32'd3, 1'b0, "divu_17d5_mthi", 1'b1);
    @(negedge clk);
    chk("mthi_with_start_hi", hi, 32'hCAFE_F00D);
    chk("mthi_with_start_busy", 32'(busy), 32'(1));
    wait_done();

    run(OP_DIV, 32'hFFFF_FF9C, 32'd0, 32'hFFFF_FF9C, 32'hFFFF_FFFF, 1'b1, "div_neg_by0");

    // Mid-operation reset discards the op and any stray start/MTHI
    issue(OP_MULT, 32'd3, 32'd4, 32'd0, 32'd0, 1'b0, "mult_aborted", 1'b0);
    repeat (4) @(posedge clk);
    #1 start = 1'b1; hi_we = 1'b1; wdata = 32'h1234_5678;
    op = OP_DIVU; operand_a = 32'd50; operand_b = 32'd5;
    @(posedge clk);
    #1 start = 1'b0; hi_we = 1'b0;
    @(negedge clk);
    chk("busy_hi_stable", hi, 32'hFFFF_FF9C);
    chk("busy_mid_op", 32'(busy), 32'(1));
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_done", 32'(done), 32'(0));
    chk("midrst_dz",   32'(div_zero), 32'(0));
    chk("midrst_hi",   hi, 32'h0);
    chk("midrst_lo",   lo, 32'h0);
    repeat (40) @(negedge clk);
    chk("midrst_still_idle", 32'(busy), 32'(0));
    chk("outstanding_results", 32'(sb.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
